// File: rtl/cart_loader.sv
// Cartridge download engine: forwards ioctl bytes to slot ROMs through a one-entry buffer,
// learns per-slot power-of-two mirror masks and drives the console / logo-skip reset.
module cart_loader #(
  parameter int unsigned AW    = 15,
  parameter int unsigned SLOTS = 4,
  parameter int unsigned DELAY = 5000000,
  parameter int unsigned PULSE = 1000,
  localparam int unsigned SW   = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                dl_active,
  input  logic                dl_wr,
  input  logic [24:0]         dl_addr,
  input  logic [7:0]          dl_data,
  input  logic [SW-1:0]       dl_slot,
  input  logic                skip_logo,
  output logic                dl_wait,
  output logic                mem_wr,
  output logic [AW-1:0]       mem_addr,
  output logic [7:0]          mem_data,
  output logic [SW-1:0]       mem_slot,
  input  logic                mem_ready,
  output logic [SLOTS*AW-1:0] slot_mask,
  output logic [SLOTS-1:0]    slot_valid,
  output logic                cpu_reset,
  output logic                overflow,
  output logic                dl_err
);

  localparam int unsigned CW = $clog2(DELAY + 1);
  localparam logic [CW-1:0] HoldLoad  = CW'(DELAY - PULSE - 1);
  localparam logic [CW-1:0] PulseLoad = CW'(PULSE - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StHold, StPulse} state_e;

  state_e          state_q, state_d;
  logic            active_q;
  logic [SW-1:0]   cur_q, cur_d;
  logic            any_q, any_d;
  logic            skip_q, skip_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full_q, full_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [SW-1:0]   bslot_q, bslot_d;
  logic [AW-1:0]   mask_q [SLOTS];
  logic [AW-1:0]   mask_d [SLOTS];
  logic [SLOTS-1:0] valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic            cpu_reset_q;
  logic            rise, fall, done_dl;

  // All bits at and below the highest set bit; OR-accumulating these gives 2^k-1.
  function automatic logic [AW-1:0] smear(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(AW); i++) r[i] = |(a >> i);
    return r;
  endfunction

  assign rise = dl_active & ~active_q;
  assign fall = ~dl_active & active_q;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    any_d   = any_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    full_d  = full_q & ~mem_ready;
    addr_d  = addr_q;
    data_d  = data_q;
    bslot_d = bslot_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    err_d   = err_q | (dl_wr & full_q);
    done_dl = 1'b0;

    if (rise) begin
      state_d          = StLoad;
      cur_d            = dl_slot;
      mask_d[dl_slot]  = '0;
      valid_d[dl_slot] = 1'b0;
      any_d            = 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (dl_wr && !full_q) begin
            if ((dl_addr >> AW) != '0) begin
              ovf_d = 1'b1;
            end else begin
              full_d        = 1'b1;
              addr_d        = dl_addr[AW-1:0];
              data_d        = dl_data;
              bslot_d       = cur_q;
              any_d         = 1'b1;
              mask_d[cur_q] = mask_q[cur_q] | smear(dl_addr[AW-1:0]);
            end
          end
          if (fall) begin
            skip_d = skip_logo;
            if (full_d) state_d = StDrain;
            else        done_dl = 1'b1;
          end
        end
        StDrain: begin
          if (!full_d) done_dl = 1'b1;
        end
        StHold: begin
          if (cnt_q == '0) begin
            state_d = StPulse;
            cnt_d   = PulseLoad;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StPulse: begin
          if (cnt_q == '0) state_d = StIdle;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: ;
      endcase

      if (done_dl) begin
        valid_d[cur_q] = any_d;
        if (skip_d) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end else begin
          state_d = StIdle;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      active_q    <= 1'b0;
      cur_q       <= '0;
      any_q       <= 1'b0;
      skip_q      <= 1'b0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      bslot_q     <= '0;
      mask_q      <= '{default: '0};
      valid_q     <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= dl_active;
      cur_q       <= cur_d;
      any_q       <= any_d;
      skip_q      <= skip_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      bslot_q     <= bslot_d;
      mask_q      <= mask_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      cpu_reset_q <= (state_d == StLoad) || (state_d == StDrain) || (state_d == StPulse);
    end
  end

  always_comb begin
    slot_mask = '0;
    for (int n = 0; n < int'(SLOTS); n++) slot_mask[n*AW +: AW] = mask_q[n];
  end

  assign dl_wait    = full_q;
  assign mem_wr     = full_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign mem_slot   = bslot_q;
  assign slot_valid = valid_q;
  assign cpu_reset  = cpu_reset_q;
  assign overflow   = ovf_q;
  assign dl_err     = err_q;

endmodule

// File: tb/tb_cart_loader.sv
// Bench for cart_loader: directed scenarios plus randomized downloads, all outputs compared
// every cycle against a behavioural model of the download/reset rules.
module tb_cart_loader;
  localparam int AW    = 15;
  localparam int SLOTS = 4;
  localparam int SW    = 2;
  localparam int DELAY = 50;
  localparam int PULSE = 10;

  logic                clk_sys = 1'b0;
  logic                reset_n;
  logic                dl_active, dl_wr, skip_logo, mem_ready;
  logic [24:0]         dl_addr;
  logic [7:0]          dl_data;
  logic [SW-1:0]       dl_slot;
  logic                dl_wait, mem_wr, cpu_reset, overflow, dl_err;
  logic [AW-1:0]       mem_addr;
  logic [7:0]          mem_data;
  logic [SW-1:0]       mem_slot;
  logic [SLOTS*AW-1:0] slot_mask;
  logic [SLOTS-1:0]    slot_valid;

  int checks = 0;
  int errors = 0;
  int dut_xfer = 0;
  bit rnd_mode = 1'b0;

  cart_loader #(.AW(AW), .SLOTS(SLOTS), .DELAY(DELAY), .PULSE(PULSE)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_slot(dl_slot), .skip_logo(skip_logo),
    .dl_wait(dl_wait), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_slot(mem_slot), .mem_ready(mem_ready), .slot_mask(slot_mask),
    .slot_valid(slot_valid), .cpu_reset(cpu_reset), .overflow(overflow), .dl_err(dl_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint        cyc = 0;
  bit            m_init = 0, m_prev, m_open, m_in_dl, m_drain, m_skip, m_any, m_full;
  bit            m_ovf, m_err;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_data;
  logic [SW-1:0] m_bslot, m_cur;
  int            m_max [SLOTS];
  logic [SLOTS-1:0] m_valid;
  longint        m_timer;
  int            m_xfer = 0;

  // Mask = smallest 2^k-1 covering the highest accepted address.
  function automatic logic [AW-1:0] exp_mask(input int mx);
    if (mx <= 0) return '0;
    return AW'((64'd1 << $clog2(mx + 1)) - 1);
  endfunction

  task automatic model_step();
    bit rise, fall, was_full, done;
    cyc++;
    if (!reset_n) begin
      m_init = 1; m_prev = 0; m_open = 0; m_in_dl = 0; m_drain = 0; m_skip = 0;
      m_any = 0; m_full = 0; m_valid = '0; m_ovf = 0; m_err = 0; m_timer = -1;
      foreach (m_max[s]) m_max[s] = 0;
      return;
    end
    rise = dl_active && !m_prev;
    fall = !dl_active && m_prev;
    m_prev = dl_active;
    was_full = m_full;
    if (m_full && mem_ready) begin
      m_full = 0;
      m_xfer++;
    end
    if (dl_wr && was_full) m_err = 1;
    if (rise) begin
      m_cur = dl_slot; m_max[dl_slot] = 0; m_valid[dl_slot] = 0; m_any = 0;
      m_in_dl = 1; m_open = 1; m_drain = 0; m_timer = -1;
    end else begin
      done = 0;
      if (m_open && dl_wr && !was_full) begin
        if (int'(dl_addr) >= (1 << AW)) m_ovf = 1;
        else begin
          m_full = 1; m_addr = dl_addr[AW-1:0]; m_data = dl_data; m_bslot = m_cur;
          m_any = 1;
          if (int'(dl_addr) > m_max[m_cur]) m_max[m_cur] = int'(dl_addr);
        end
      end
      if (m_open && fall) begin
        m_open = 0; m_skip = skip_logo;
        if (m_full) m_drain = 1; else done = 1;
      end else if (m_drain && !m_full) begin
        m_drain = 0; done = 1;
      end
      if (done) begin
        m_valid[m_cur] = m_any; m_in_dl = 0;
        if (m_skip) m_timer = cyc;
      end
      if (m_timer >= 0 && cyc - m_timer >= DELAY) m_timer = -1;
    end
  endtask

  task automatic compare();
    logic [SLOTS*AW-1:0] em;
    bit er;
    em = '0;
    for (int s = 0; s < SLOTS; s++) em[s*AW +: AW] = exp_mask(m_max[s]);
    er = m_in_dl || (m_timer >= 0 && cyc - m_timer >= DELAY - PULSE);
    chk("mem_wr", mem_wr, m_full);
    chk("dl_wait", dl_wait, m_full);
    chk("slot_mask", slot_mask, em);
    chk("slot_valid", slot_valid, m_valid);
    chk("cpu_reset", cpu_reset, er);
    chk("overflow", overflow, m_ovf);
    chk("dl_err", dl_err, m_err);
    if (m_full) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_data", mem_data, m_data);
      chk("mem_slot", mem_slot, m_bslot);
    end
    if (mem_wr && mem_ready) dut_xfer++;
  endtask

  initial forever begin
    @(posedge clk_sys);
    model_step();
  end

  initial forever begin
    @(negedge clk_sys);
    if (m_init) compare();
  end

  initial forever begin
    @(posedge clk_sys);
    #1;
    if (rnd_mode) mem_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [SW-1:0] slot);
    dl_slot = slot; dl_active = 1; step();
  endtask

  task automatic end_dl(input logic skip);
    dl_active = 0; skip_logo = skip; step(); skip_logo = 0;
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    int k;
    dl_addr = a; dl_data = d; dl_wr = 1; step(); dl_wr = 0;
    k = 0;
    while (dl_wait && k < 10) begin
      step();
      k++;
    end
    chk("wr_drain", dl_wait, 1'b0);
  endtask

  initial begin
    int lo, hi, lo2;
    reset_n = 0; dl_active = 0; dl_wr = 0; dl_addr = '0; dl_data = '0; dl_slot = '0;
    skip_logo = 0; mem_ready = 1;
    repeat (3) step();
    reset_n = 1; step();
    chk("rst_cpu_reset", cpu_reset, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_valid", slot_valid, 4'b0000);
    chk("rst_mask", slot_mask, 64'd0);

    // Sequential 8 KiB download to slot 2.
    dut_xfer = 0;
    start_dl(2'd2);
    chk("t1_cpu_reset_load", cpu_reset, 1'b1);
    for (int a = 0; a < 8192; a++) wr(25'(a), 8'(a) ^ 8'(a >> 5));
    end_dl(1'b0);
    chk("t1_mask2", slot_mask[2*AW +: AW], 15'h1FFF);
    chk("t1_all_masks", slot_mask, 64'h1FFF << 30);
    chk("t1_valid", slot_valid, 4'b0100);
    chk("t1_dut_xfers", dut_xfer, 8192);
    chk("t1_model_xfers", m_xfer, 8192);

    // Order independence and the addr-0-only case.
    start_dl(2'd1);
    wr(25'h0003, 8'h11); wr(25'h2000, 8'h22); wr(25'h0100, 8'h33);
    end_dl(1'b0);
    chk("t2_mask1", slot_mask[1*AW +: AW], 15'h3FFF);
    start_dl(2'd3);
    wr(25'h0000, 8'h44);
    end_dl(1'b0);
    chk("t2_mask3_zero", slot_mask[3*AW +: AW], 15'h0000);
    chk("t2_valid3", slot_valid[3], 1'b1);

    // Out-of-range byte.
    start_dl(2'd0);
    wr(25'h8000, 8'h55);
    chk("t3_no_mem_wr", mem_wr, 1'b0);
    chk("t3_overflow", overflow, 1'b1);
    chk("t3_mask0", slot_mask[0*AW +: AW], 15'h0000);
    end_dl(1'b0);
    start_dl(2'd0);
    end_dl(1'b0);
    chk("t3_overflow_sticky", overflow, 1'b1);

    // Memory stall, dl_err and DRAIN.
    mem_ready = 0;
    start_dl(2'd1);
    dl_addr = 25'h0042; dl_data = 8'h99; dl_wr = 1; step(); dl_wr = 0;
    chk("t4_wait", dl_wait, 1'b1);
    chk("t4_addr", mem_addr, 15'h0042);
    step();
    dl_addr = 25'h0077; dl_data = 8'h12; dl_wr = 1; step(); dl_wr = 0;
    chk("t4_err", dl_err, 1'b1);
    chk("t4_addr_held", mem_addr, 15'h0042);
    chk("t4_data_held", mem_data, 8'h99);
    end_dl(1'b0);
    chk("t4_drain_reset", cpu_reset, 1'b1);
    chk("t4_valid_pending", slot_valid[1], 1'b0);
    step();
    chk("t4_still_wr", mem_wr, 1'b1);
    mem_ready = 1; step();
    chk("t4_valid_after", slot_valid[1], 1'b1);
    chk("t4_mem_wr_done", mem_wr, 1'b0);
    chk("t4_reset_done", cpu_reset, 1'b0);

    // Logo-skip second reset.
    start_dl(2'd0);
    wr(25'h0010, 8'h01);
    chk("t5_reset_in_dl", cpu_reset, 1'b1);
    end_dl(1'b1);
    lo = 0; hi = 0; lo2 = 0;
    for (int k = 0; k < 60; k++) begin
      if (cpu_reset) hi++;
      else if (hi == 0) lo++;
      else lo2++;
      step();
    end
    chk("t5_low_run", lo, DELAY - PULSE);
    chk("t5_pulse_len", hi, PULSE);
    chk("t5_low_after", lo2, 10);
    start_dl(2'd1);
    end_dl(1'b1);
    repeat (20) step();
    dl_slot = 2'd1; dl_active = 1; step();
    chk("t5_abort_reset", cpu_reset, 1'b1);
    end_dl(1'b0);
    step();

    // Randomized downloads.
    rnd_mode = 1;
    for (int n = 0; n < 40; n++) begin
      start_dl(SW'($urandom_range(0, SLOTS - 1)));
      repeat ($urandom_range(0, 12)) begin
        if ($urandom_range(0, 9) == 0) dl_addr = 25'h8000 + 25'($urandom_range(0, 4095));
        else dl_addr = 25'($urandom & ((32'd1 << $urandom_range(0, AW)) - 1));
        dl_data = 8'($urandom); dl_wr = 1; step(); dl_wr = 0;
        repeat ($urandom_range(0, 3)) step();
      end
      end_dl(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 70)) step();
    end
    rnd_mode = 0; mem_ready = 1;
    repeat (80) step();

    // Reset with a full buffer.
    mem_ready = 0;
    start_dl(2'd2);
    dl_addr = 25'h0123; dl_data = 8'h5A; dl_wr = 1; step(); dl_wr = 0;
    chk("t6_full", mem_wr, 1'b1);
    reset_n = 0; dl_active = 0; step();
    chk("t6_mem_wr", mem_wr, 1'b0);
    chk("t6_cpu_reset", cpu_reset, 1'b0);
    chk("t6_masks", slot_mask, 64'd0);
    chk("t6_valid", slot_valid, 4'b0000);
    chk("t6_flags", {overflow, dl_err}, 2'b00);
    reset_n = 1; mem_ready = 1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
